// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: immediate/mode in, extended operand out.
// slave = the extension unit, master = the producer/consumer side.
interface imm_extend_pipe_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_neg;

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg
  );

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined MIPS immediate extender (SIGN/ZERO/UPPER/BRANCH), 1-cycle latency,
// 2-entry skid. Define IMM_EXT_STATS_EN to add the saturating stat_neg_cnt port.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  imm_extend_pipe_if.slave bus
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_neg_cnt
`endif
);

  if (IN_W < 2 || IN_W >= OUT_W || CNT_W < 1) begin : g_bad_param
    $error("imm_extend_pipe: illegal IN_W/OUT_W/CNT_W combination");
  end

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b10
  } state_e;

  state_e           state_q;
  logic [OUT_W-1:0] main_q;
  logic [OUT_W-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_d;
  mode_e            mode;
  logic             in_xfer;
  logic             out_xfer;

  assign mode     = mode_e'(bus.in_mode);
  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  always_comb begin
    sext  = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
    ext_d = sext;
    case (mode)
      MODE_SIGN:   ext_d = sext;
      MODE_ZERO:   ext_d = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
      MODE_UPPER:  ext_d = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: ext_d = sext << 2;
      default:     ext_d = sext;
    endcase
  end

  // Datapath registers only load on an accepted transfer, so X on the
  // immediate or mode while in_valid is low never reaches the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            main_q      <= ext_d;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= ext_d;
          end else if (in_xfer) begin
            skid_q     <= ext_d;
            state_q    <= S_TWO;
            in_ready_q <= 1'b0;
          end else if (out_xfer) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_TWO: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.out_neg   = main_q[OUT_W-1];

`ifdef IMM_EXT_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] neg_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_cnt_q <= '0;
    end else if (out_xfer && main_q[OUT_W-1] && (neg_cnt_q != '1)) begin
      neg_cnt_q <= neg_cnt_q + CNT_ONE;
    end
  end

  assign stat_neg_cnt = neg_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (IN_W=16, OUT_W=32, CNT_W=2).
module tb_imm_extend_pipe;

  localparam logic [1:0] M_SIGN   = 2'b00;
  localparam logic [1:0] M_ZERO   = 2'b01;
  localparam logic [1:0] M_UPPER  = 2'b10;
  localparam logic [1:0] M_BRANCH = 2'b11;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

`ifdef IMM_EXT_STATS_EN
  logic [1:0] stat_neg_cnt;
`endif

  imm_extend_pipe #(
    .IN_W (16),
    .OUT_W(32),
    .CNT_W(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef IMM_EXT_STATS_EN
    ,
    .stat_neg_cnt(stat_neg_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode);
    bus.in_valid = v;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] b2b_imm [8] = '{16'h0001, 16'h7FFF, 16'h8001, 16'hFFFF,
                               16'h1234, 16'hABCD, 16'h0000, 16'h8000};
  logic [31:0] b2b_exp [8] = '{32'h00000001, 32'h00007FFF, 32'hFFFF8001, 32'hFFFFFFFF,
                               32'h00001234, 32'hFFFFABCD, 32'h00000000, 32'hFFFF8000};
  logic [15:0] md_imm  [4] = '{16'h8000, 16'h1234, 16'hFFFF, 16'h4000};
  logic [1:0]  md_mode [4] = '{M_ZERO, M_UPPER, M_BRANCH, M_BRANCH};
  logic [31:0] md_exp  [4] = '{32'h00008000, 32'h12340000, 32'hFFFFFFFC, 32'h00010000};

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_imm    = 'x;
    bus.in_mode   = 'x;
    bus.out_ready = 1'b1;
    #22;
    reset = 1'b0;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("rst_out_data",  bus.out_data,           32'h0);
    check("rst_out_neg",   {31'b0, bus.out_neg},   32'd0);
    step();
    // X on imm/mode with in_valid low must not leak
    check("idle_x_data",  bus.out_data,           32'h0);
    check("idle_x_valid", {31'b0, bus.out_valid}, 32'd0);

    // SIGN basics, one cycle latency
    drive(1'b1, 16'h8000, M_SIGN);
    step();
    check("sign8000_valid", {31'b0, bus.out_valid}, 32'd1);
    check("sign8000_data",  bus.out_data,           32'hFFFF8000);
    check("sign8000_neg",   {31'b0, bus.out_neg},   32'd1);
    drive(1'b1, 16'h0000, M_SIGN);
    step();
    check("sign0000_data", bus.out_data,         32'h00000000);
    check("sign0000_neg",  {31'b0, bus.out_neg}, 32'd0);
    drive(1'b0, 'x, 'x);
    step();
    check("drain_valid", {31'b0, bus.out_valid}, 32'd0);

    // Other modes
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, md_imm[i], md_mode[i]);
      step();
      check($sformatf("mode%0d_data", i), bus.out_data, md_exp[i]);
      check($sformatf("mode%0d_neg", i), {31'b0, bus.out_neg}, {31'b0, md_exp[i][31]});
    end
    drive(1'b0, 'x, 'x);
    step();

    // Stall with skid fill
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0001, M_SIGN);
    step();
    check("stall1_in_ready", {31'b0, bus.in_ready}, 32'd1);
    drive(1'b1, 16'h0002, M_SIGN);
    step();
    drive(1'b0, 'x, 'x);
    check("stall2_in_ready", {31'b0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold%0d_data", i), bus.out_data, 32'h00000001);
      check($sformatf("hold%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    step();
    check("unstall_data2",    bus.out_data,           32'h00000002);
    check("unstall_in_ready", {31'b0, bus.in_ready},  32'd1);
    check("unstall_valid",    {31'b0, bus.out_valid}, 32'd1);
    step();
    check("unstall_empty", {31'b0, bus.out_valid}, 32'd0);

    // Back-to-back full throughput
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, b2b_imm[i], M_SIGN);
      step();
      check($sformatf("b2b%0d_data", i), bus.out_data, b2b_exp[i]);
      check($sformatf("b2b%0d_rdy", i), {31'b0, bus.in_ready}, 32'd1);
    end
    drive(1'b0, 'x, 'x);
    step();

    // Async reset with two items buffered
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0011, M_SIGN);
    step();
    drive(1'b1, 16'h8022, M_SIGN);
    step();
    drive(1'b0, 'x, 'x);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid",    {31'b0, bus.out_valid}, 32'd0);
    check("arst_data",     bus.out_data,           32'h0);
    check("arst_neg",      {31'b0, bus.out_neg},   32'd0);
    check("arst_in_ready", {31'b0, bus.in_ready},  32'd1);
    #2;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("post_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("post_rst_rdy",   {31'b0, bus.in_ready},  32'd1);
    drive(1'b1, 16'h0005, M_ZERO);
    step();
    drive(1'b0, 'x, 'x);
    check("post_rst_data", bus.out_data, 32'h00000005);
    step();

`ifdef IMM_EXT_STATS_EN
    begin
      logic [15:0] st_imm [7] = '{16'h0001, 16'h0002, 16'h8000, 16'hFFFF,
                                  16'h9000, 16'hA000, 16'hF000};
      logic [1:0]  st_exp [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      check("stat_rst", {30'b0, stat_neg_cnt}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        if (i < 7) drive(1'b1, st_imm[i], M_SIGN);
        else       drive(1'b0, 'x, 'x);
        step();
        check($sformatf("stat%0d_cnt", i), {30'b0, stat_neg_cnt}, {30'b0, st_exp[i]});
      end
      drive(1'b0, 'x, 'x);
      step();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
